// File: rtl/regfile_pkg.sv
// Shared constants and parameter defaults for the multi-ported register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_REGBITS = 5;
  localparam int unsigned DEF_NRD     = 2;
  localparam int unsigned DEF_NWR     = 2;

  localparam int unsigned ZERO_REG   = 0;
  // Replicate to any width: {WIDTH{CONST_ZERO}}.
  localparam logic        CONST_ZERO = 1'b0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus of regfile_mp; master is the datapath, slave the register file.
interface regfile_mp_if #(
    parameter int unsigned WIDTH   = regfile_pkg::DEF_WIDTH,
    parameter int unsigned REGBITS = regfile_pkg::DEF_REGBITS,
    parameter int unsigned NRD     = regfile_pkg::DEF_NRD,
    parameter int unsigned NWR     = regfile_pkg::DEF_NWR
) ();

    logic [NWR-1:0]         we_i;
    logic [NWR*REGBITS-1:0] wa_i;
    logic [NWR*WIDTH-1:0]   wd_i;
    logic [NRD*REGBITS-1:0] ra_i;
    logic [NRD*WIDTH-1:0]   rd_o;
    logic [NRD-1:0]         rd_busy_o;
    logic                   rsv_i;
    logic [REGBITS-1:0]     rsv_wa_i;
    logic                   flush_i;

    modport master (
        output we_i, wa_i, wd_i, ra_i, rsv_i, rsv_wa_i, flush_i,
        input  rd_o, rd_busy_o
    );

    modport slave (
        input  we_i, wa_i, wd_i, ra_i, rsv_i, rsv_wa_i, flush_i,
        output rd_o, rd_busy_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy vector tracking outstanding producers; flush > reserve > write-clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned REGBITS = DEF_REGBITS,
    parameter int unsigned NRD     = DEF_NRD,
    parameter int unsigned NWR     = DEF_NWR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         we_i,
    input  logic [NWR*REGBITS-1:0] wa_i,
    input  logic                   rsv_i,
    input  logic [REGBITS-1:0]     rsv_wa_i,
    input  logic                   flush_i,
    input  logic [NRD*REGBITS-1:0] ra_i,
    output logic [NRD-1:0]         busy_o
);

    localparam int unsigned DEPTH = 2 ** REGBITS;

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int unsigned k = 0; k < NWR; k++) begin
                if (we_i[k]) busy_d[wa_i[k*REGBITS +: REGBITS]] = 1'b0;
            end
            // Applied after the clears: the reserving instruction is the younger producer.
            if (rsv_i) busy_d[rsv_wa_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            busy_o[j] = busy_q[ra_i[j*REGBITS +: REGBITS]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file (r0 hardwired to zero) with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REGBITS = DEF_REGBITS,
    parameter int unsigned NRD     = DEF_NRD,
    parameter int unsigned NWR     = DEF_NWR
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** REGBITS;
    localparam logic [REGBITS-1:0] R0 = REGBITS'(ZERO_REG);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [NRD-1:0]   sb_busy;
    logic [NRD-1:0]   fwd_hit;

    // Ascending port order so the highest-index writer wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{CONST_ZERO}};
        end else begin
            for (int unsigned k = 0; k < NWR; k++) begin
                if (bus.we_i[k] && bus.wa_i[k*REGBITS +: REGBITS] != R0) begin
                    mem_q[bus.wa_i[k*REGBITS +: REGBITS]] <= bus.wd_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        bus.rd_o = '0;
        fwd_hit  = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            if (bus.ra_i[j*REGBITS +: REGBITS] != R0) begin
                bus.rd_o[j*WIDTH +: WIDTH] = mem_q[bus.ra_i[j*REGBITS +: REGBITS]];
            end
`ifdef REGFILE_BYPASS_EN
            // A write suppressed by reset must not be forwarded either.
            for (int unsigned k = 0; k < NWR; k++) begin
                if (!rst && bus.we_i[k] && bus.ra_i[j*REGBITS +: REGBITS] != R0 &&
                    bus.wa_i[k*REGBITS +: REGBITS] == bus.ra_i[j*REGBITS +: REGBITS]) begin
                    bus.rd_o[j*WIDTH +: WIDTH] = bus.wd_i[k*WIDTH +: WIDTH];
                    fwd_hit[j] = 1'b1;
                end
            end
`endif
        end
    end

    regfile_scoreboard #(
        .REGBITS (REGBITS),
        .NRD     (NRD),
        .NWR     (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.we_i),
        .wa_i     (bus.wa_i),
        .rsv_i    (bus.rsv_i),
        .rsv_wa_i (bus.rsv_wa_i),
        .flush_i  (bus.flush_i),
        .ra_i     (bus.ra_i),
        .busy_o   (sb_busy)
    );

    assign bus.rd_busy_o = sb_busy & ~fwd_hit;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector and reference-model bench for regfile_mp (both REGFILE_BYPASS_EN builds).
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned RB = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .REGBITS(RB), .NRD(NR), .NWR(NW)) bus ();

    regfile_mp #(.WIDTH(W), .REGBITS(RB), .NRD(NR), .NWR(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  rwa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic r, input logic [1:0] we, input logic [4:0] wa0,
                                input logic [31:0] wd0, input logic [4:0] wa1,
                                input logic [31:0] wd1, input logic rsv, input logic [4:0] rwa,
                                input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb);
        vec_t v;
        v.r = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rsv = rsv; v.rwa = rwa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive just after an edge, compare combinational outputs well before the next one.
    task automatic run(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        rst = v.r;
        bus.we_i = v.we;
        bus.wa_i = {v.wa1, v.wa0};
        bus.wd_i = {v.wd1, v.wd0};
        bus.rsv_i = v.rsv;
        bus.rsv_wa_i = v.rwa;
        bus.flush_i = v.fl;
        bus.ra_i = {v.ra1, v.ra0};
        #2;
        check({tag, " rd"}, 64'(bus.rd_o), {v.e1, v.e0});
        check({tag, " busy"}, 64'(bus.rd_busy_o), 64'(v.eb));
    endtask

    vec_t tbl[21];
    logic [31:0] m [32];
    logic [31:0] b;

    initial begin
        //                r  we    wa0 wd0           wa1 wd1      rsv rwa fl ra0 ra1 e0     e1     eb
        tbl[0]  = mk(1, 2'b01, 5, 32'hDEADBEEF, 0, 0,       0, 0, 0, 5, 0, 0,     0,     2'b00);
        tbl[1]  = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 5, 1, 0,     0,     2'b00);
        tbl[2]  = mk(0, 2'b11, 3, 32'h11,       3, 32'h22,  0, 0, 0, 4, 2, 0,     0,     2'b00);
        tbl[3]  = mk(0, 2'b01, 0, 32'hFFFF,     0, 0,       0, 0, 0, 3, 0, 32'h22, 0,    2'b00);
        tbl[4]  = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 0, 3, 0,     32'h22, 2'b00);
        tbl[5]  = mk(0, 2'b00, 0, 0,            0, 0,       1, 4, 0, 4, 3, 0,     32'h22, 2'b00);
        tbl[6]  = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 4, 3, 0,     32'h22, 2'b01);
        tbl[7]  = mk(0, 2'b01, 4, 32'h44,       0, 0,       0, 0, 0, 3, 3, 32'h22, 32'h22, 2'b00);
        tbl[8]  = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 4, 0, 32'h44, 0,    2'b00);
        tbl[9]  = mk(0, 2'b10, 0, 0,            4, 32'h55,  1, 4, 0, 3, 0, 32'h22, 0,    2'b00);
        tbl[10] = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 4, 0, 32'h55, 0,    2'b01);
        tbl[11] = mk(0, 2'b00, 0, 0,            0, 0,       1, 2, 0, 4, 2, 32'h55, 0,    2'b01);
        tbl[12] = mk(0, 2'b00, 0, 0,            0, 0,       1, 9, 0, 2, 4, 0,     32'h55, 2'b11);
        tbl[13] = mk(0, 2'b00, 0, 0,            0, 0,       1, 0, 0, 9, 2, 0,     0,     2'b11);
        tbl[14] = mk(0, 2'b00, 0, 0,            0, 0,       1, 6, 1, 0, 9, 0,     0,     2'b10);
        tbl[15] = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 6, 9, 0,     0,     2'b00);
        tbl[16] = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 2, 4, 0,     32'h55, 2'b00);
        tbl[17] = mk(0, 2'b00, 0, 0,            0, 0,       1, 7, 0, 0, 0, 0,     0,     2'b00);
        tbl[18] = mk(1, 2'b01, 8, 32'h77,       0, 0,       1, 8, 0, 7, 4, 0,     32'h55, 2'b01);
        tbl[19] = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 7, 4, 0,     0,     2'b00);
        tbl[20] = mk(0, 2'b00, 0, 0,            0, 0,       0, 0, 0, 8, 8, 0,     0,     2'b00);

        rst = 1'b1;
        bus.we_i = '0; bus.wa_i = '0; bus.wd_i = '0; bus.ra_i = '0;
        bus.rsv_i = 1'b0; bus.rsv_wa_i = '0; bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 21; i++) run(tbl[i], $sformatf("row%0d", i));

        // Same-cycle write/read of reserved r7, both ports writing it.
        run(mk(0, 2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 2'b00), "byp_rsv");
`ifdef REGFILE_BYPASS_EN
        run(mk(0, 2'b11, 7, 32'h11, 7, 32'hA5, 0, 0, 0, 7, 7, 32'hA5, 32'hA5, 2'b00), "byp_same");
`else
        run(mk(0, 2'b11, 7, 32'h11, 7, 32'hA5, 0, 0, 0, 7, 7, 0, 0, 2'b11), "byp_same");
`endif
        run(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'hA5, 0, 2'b00), "byp_next");

        // Reset back to a known-zero state, then compare against a reference model.
        run(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), "rst_again");
        for (int i = 0; i < 32; i++) m[i] = '0;
        b = '0;

        for (int c = 0; c < 1000; c++) begin
            logic [4:0]  wa [2];
            logic [31:0] wd [2];
            logic [4:0]  ra [2];
            logic [31:0] erd [2];
            logic [1:0]  eb;
            logic [1:0]  we;
            logic        rsv, fl;
            logic [4:0]  rwa;
            @(posedge clk);
            #1;
            rst = 1'b0;
            we  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                wa[k] = 5'($urandom_range(0, 15));
                wd[k] = $urandom;
                ra[k] = 5'($urandom_range(0, 15));
            end
            rsv = 1'($urandom_range(0, 1));
            rwa = 5'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 15) == 0);
            bus.we_i = we; bus.wa_i = {wa[1], wa[0]}; bus.wd_i = {wd[1], wd[0]};
            bus.ra_i = {ra[1], ra[0]}; bus.rsv_i = rsv; bus.rsv_wa_i = rwa; bus.flush_i = fl;
            for (int j = 0; j < 2; j++) begin
                erd[j] = (ra[j] == 0) ? 32'h0 : m[ra[j]];
                eb[j]  = (ra[j] == 0) ? 1'b0 : b[ra[j]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < 2; k++) begin
                    if (we[k] && ra[j] != 0 && wa[k] == ra[j]) begin
                        erd[j] = wd[k];
                        eb[j]  = 1'b0;
                    end
                end
`endif
            end
            #2;
            check($sformatf("rand%0d rd", c), 64'(bus.rd_o), {erd[1], erd[0]});
            check($sformatf("rand%0d busy", c), 64'(bus.rd_busy_o), 64'(eb));
            for (int k = 0; k < 2; k++) if (we[k] && wa[k] != 0) m[wa[k]] = wd[k];
            if (fl) begin
                b = '0;
            end else begin
                for (int k = 0; k < 2; k++) if (we[k]) b[wa[k]] = 1'b0;
                if (rsv) b[rwa] = 1'b1;
            end
            b[0] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
